inc_stream: RTL and testbench
=============================

INC_STREAM -- requirements
Module: inc_stream

Interface
REQ-001 Parameter: DATAWIDTH, default 2, bit width of operand and result.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, synchronous, active-high.
REQ-004 a_valid  input  1  upstream operand valid.
REQ-005 a_ready  output  1  block can accept an operand this cycle.
REQ-006 a  input  DATAWIDTH  operand.
REQ-007 d_valid  output  1  result valid.
REQ-008 d_ready  input  1  downstream accepts result this cycle.
REQ-009 d  output  DATAWIDTH  result, a+1.
REQ-010 ovf  output  1  result produced from all-ones operand; qualified by d_valid.

Function
REQ-011 The block SHALL accept an operand on any rising edge where a_valid=1 and a_ready=1 (accept event).
REQ-012 The block SHALL emit a result on any rising edge where d_valid=1 and d_ready=1 (drain event).
REQ-013 Result SHALL be (a+1) mod 2^DATAWIDTH, with ovf=1 exactly when a equals all ones.
REQ-014 Latency SHALL be 1 cycle: an operand accepted at edge N is presented on d/d_valid after edge N when the buffer was empty.
REQ-015 Storage SHALL be 2 entries (output register plus skid register), in FIFO order; results never reorder, drop or duplicate.
REQ-016 FSM states: EMPTY (0 entries), ONE (1), FULL (2).
REQ-017 Transitions: EMPTY->ONE on accept; ONE->FULL on accept without drain; ONE->EMPTY on drain without accept; ONE->ONE on simultaneous accept and drain; FULL->ONE on drain.
REQ-018 a_ready SHALL be a registered output, 1 in EMPTY and ONE, 0 in FULL.
REQ-019 d_valid SHALL be 1 in ONE and FULL, 0 in EMPTY.
REQ-020 d and ovf SHALL stay stable while d_valid=1 and d_ready=0.
REQ-021 Simultaneous accept and drain in ONE SHALL sustain 1 result per cycle indefinitely.
REQ-022 In FULL, a drain SHALL move the skid entry into the output register on the same edge.
REQ-023 a_valid while a_ready=0 SHALL have no effect.
REQ-024 d and ovf SHALL be don't-care for checking while d_valid=0.

Reset
REQ-025 When Rst=1 at a rising edge, the FSM SHALL enter EMPTY, with d_valid=0, a_ready=1, d=0 and ovf=0 after that edge.
REQ-026 Reset SHALL take priority over simultaneous accept and drain events; in-flight entries are discarded.
REQ-027 The first accept SHALL be possible on the first edge with Rst=0.

Configuration
REQ-028 Macro INC_STREAM_SAT_EN: when defined, an all-ones operand SHALL yield d = all ones (saturate) with ovf=1.
REQ-029 When INC_STREAM_SAT_EN is undefined, an all-ones operand SHALL wrap to d=0 with ovf=1.
REQ-030 The macro SHALL change no other timing or handshake behaviour.

Structure
REQ-031 Shared package inc_pkg SHALL hold the FSM state encodings (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the DATAWIDTH default constant.
REQ-032 Combinational sub-module inc_core (a -> sum, ovf, saturation under the macro) SHALL compute the result; inc_stream holds all registers and the FSM.

Verification
REQ-033 DATAWIDTH=2, Rst held 2 cycles then released -> d_valid=0, a_ready=1, d=0, ovf=0; a=1, a_valid=1 for one cycle, d_ready=1 -> next cycle d=2, ovf=0, d_valid=1 for exactly 1 cycle.
REQ-034 a = 0,1,2,3 back-to-back with d_ready=1 -> d = 1,2,3,0 on consecutive cycles, ovf only on the last; with INC_STREAM_SAT_EN the last result is d=3, ovf=1.
REQ-035 d_ready=0, a = 0,1,2 offered on consecutive cycles -> first two accepted, a_ready=0 from the cycle after the second accept, d held at 1; d_ready=1 -> d=1 then 2, then a=2 accepted -> d=3.
REQ-036 Random a_valid/d_ready at 50% each, 1000 operands -> output sequence equals the input sequence plus 1 (mod 4), in order, with no loss.
REQ-037 FULL state with Rst pulsed for 1 cycle -> EMPTY, d_valid=0, a_ready=1; no stale result appears afterward.
REQ-038 DATAWIDTH=8, a=8'hFF -> d=8'h00, ovf=1 (d=8'hFF with INC_STREAM_SAT_EN); a=8'h7F -> d=8'h80, ovf=0.

Source files
------------

// File: rtl/inc_pkg.sv
// rtl/inc_pkg.sv - shared state encodings and width default for inc_stream
package inc_pkg;

  localparam int INC_DATAWIDTH = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } inc_state_e;

endpackage

// File: rtl/inc_core.sv
// rtl/inc_core.sv - combinational increment with all-ones detection
// Saturation on all-ones operand selected by INC_STREAM_SAT_EN.
module inc_core
  import inc_pkg::*;
#(
  parameter int DATAWIDTH = INC_DATAWIDTH
) (
  input  logic [DATAWIDTH-1:0] i_a,
  output logic [DATAWIDTH-1:0] o_sum,
  output logic                 o_ovf
);

  logic w_all_ones;

  assign w_all_ones = &i_a;
  assign o_ovf      = w_all_ones;

`ifdef INC_STREAM_SAT_EN
  assign o_sum = w_all_ones ? i_a : i_a + DATAWIDTH'(1);
`else
  assign o_sum = i_a + DATAWIDTH'(1);
`endif

endmodule

// File: rtl/inc_stream.sv
// rtl/inc_stream.sv - 2-entry skid-buffered incrementer stream (a -> a+1)
// Optional saturation via INC_STREAM_SAT_EN, implemented inside inc_core.
module inc_stream
  import inc_pkg::*;
#(
  parameter int DATAWIDTH = INC_DATAWIDTH
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [DATAWIDTH-1:0] a,
  output logic                 d_valid,
  input  logic                 d_ready,
  output logic [DATAWIDTH-1:0] d,
  output logic                 ovf
);

  inc_state_e           r_state;
  inc_state_e           w_next_state;
  logic                 r_a_ready;
  logic [DATAWIDTH-1:0] r_out_d;
  logic                 r_out_ovf;
  logic [DATAWIDTH-1:0] r_skid_d;
  logic                 r_skid_ovf;

  logic [DATAWIDTH-1:0] w_sum;
  logic                 w_core_ovf;
  logic                 w_accept;
  logic                 w_drain;
  logic                 w_load_out_new;
  logic                 w_load_out_skid;
  logic                 w_load_skid;

  inc_core #(
    .DATAWIDTH (DATAWIDTH)
  ) u_core (
    .i_a   (a),
    .o_sum (w_sum),
    .o_ovf (w_core_ovf)
  );

  assign d_valid  = (r_state != EMPTY);
  assign a_ready  = r_a_ready;
  assign d        = r_out_d;
  assign ovf      = r_out_ovf;
  assign w_accept = a_valid & r_a_ready;
  assign w_drain  = d_valid & d_ready;

  always_comb begin
    w_next_state    = r_state;
    w_load_out_new  = 1'b0;
    w_load_out_skid = 1'b0;
    w_load_skid     = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_next_state   = ONE;
          w_load_out_new = 1'b1;
        end
      end
      ONE: begin
        case ({w_accept, w_drain})
          2'b11: w_load_out_new = 1'b1;
          2'b10: begin
            w_next_state = FULL;
            w_load_skid  = 1'b1;
          end
          2'b01: w_next_state = EMPTY;
          default: ;
        endcase
      end
      FULL: begin
        // Output register refills from the skid entry on the draining edge.
        if (w_drain) begin
          w_next_state    = ONE;
          w_load_out_skid = 1'b1;
        end
      end
      default: w_next_state = EMPTY;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= EMPTY;
      r_a_ready  <= 1'b1;
      r_out_d    <= '0;
      r_out_ovf  <= 1'b0;
      r_skid_d   <= '0;
      r_skid_ovf <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_a_ready <= (w_next_state != FULL);
      if (w_load_out_new) begin
        r_out_d   <= w_sum;
        r_out_ovf <= w_core_ovf;
      end else if (w_load_out_skid) begin
        r_out_d   <= r_skid_d;
        r_out_ovf <= r_skid_ovf;
      end
      if (w_load_skid) begin
        r_skid_d   <= w_sum;
        r_skid_ovf <= w_core_ovf;
      end
    end
  end

endmodule

// File: tb/tb_inc_stream.sv
// tb/tb_inc_stream.sv - randomized self-checking bench for inc_stream (2-bit and 8-bit)
module tb_inc_stream;

`ifdef INC_STREAM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       a_valid, d_ready, a_ready, d_valid, ovf;
  logic [1:0] a, d;
  logic       a8_valid, d8_ready, a8_ready, d8_valid, ovf8;
  logic [7:0] a8, d8;

  int vectors;
  int miscompares;

  inc_stream #(.DATAWIDTH(2)) dut (
    .Clk(clk), .Rst(rst), .a_valid(a_valid), .a_ready(a_ready), .a(a),
    .d_valid(d_valid), .d_ready(d_ready), .d(d), .ovf(ovf)
  );

  inc_stream #(.DATAWIDTH(8)) dut8 (
    .Clk(clk), .Rst(rst), .a_valid(a8_valid), .a_ready(a8_ready), .a(a8),
    .d_valid(d8_valid), .d_ready(d8_ready), .d(d8), .ovf(ovf8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_d(int av, int w);
    int maxv;
    maxv = (1 << w) - 1;
    if (av == maxv) return SAT ? maxv : 0;
    return av + 1;
  endfunction

  function automatic int ref_ovf(int av, int w);
    return (av == (1 << w) - 1) ? 1 : 0;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b1; a = 2'd3; d_ready = 1'b0;
    a8_valid = 1'b0; a8 = 8'd0; d8_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;
    vectors++;
    if ({d_valid, a_ready, d, ovf} !== {1'b0, 1'b1, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: got valid=%0b ready=%0b d=%0d ovf=%0b, expected 0 1 0 0", d_valid, a_ready, d, ovf);
    end
    vectors++;
    if ({d8_valid, a8_ready, d8, ovf8} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset8: got valid=%0b ready=%0b d=%0h ovf=%0b, expected 0 1 0 0", d8_valid, a8_ready, d8, ovf8);
    end
  endtask

  task automatic test_single();
    a = 2'd1; a_valid = 1'b1; d_ready = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    vectors++;
    if ({d_valid, d, ovf} !== {1'b1, 2'd2, 1'b0}) begin
      miscompares++;
      $display("FAIL single: got valid=%0b d=%0d ovf=%0b, expected 1 2 0", d_valid, d, ovf);
    end
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_once: got valid=%0b, expected 0", d_valid);
    end
  endtask

  task automatic test_back_to_back();
    d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 2'(i); a_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if ({d_valid, a_ready, int'(d), int'(ovf)} !== {1'b1, 1'b1, ref_d(i, 2), ref_ovf(i, 2)}) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got valid=%0b ready=%0b d=%0d ovf=%0b, expected 1 1 %0d %0d",
                 i, d_valid, a_ready, d, ovf, ref_d(i, 2), ref_ovf(i, 2));
      end
    end
    a_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got valid=%0b, expected 0", d_valid);
    end
  endtask

  task automatic test_backpressure();
    d_ready = 1'b0; a = 2'd0; a_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({d_valid, a_ready, d} !== {1'b1, 1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL bp_one: got valid=%0b ready=%0b d=%0d, expected 1 1 1", d_valid, a_ready, d);
    end
    a = 2'd1;
    @(negedge clk);
    vectors++;
    if ({a_ready, d} !== {1'b0, 2'd1}) begin
      miscompares++;
      $display("FAIL bp_full: got ready=%0b d=%0d, expected 0 1", a_ready, d);
    end
    a = 2'd2;
    @(negedge clk);
    vectors++;
    if ({d_valid, a_ready, d} !== {1'b1, 1'b0, 2'd1}) begin
      miscompares++;
      $display("FAIL bp_hold: got valid=%0b ready=%0b d=%0d, expected 1 0 1", d_valid, a_ready, d);
    end
    d_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({d_valid, a_ready, d} !== {1'b1, 1'b1, 2'd2}) begin
      miscompares++;
      $display("FAIL bp_skid: got valid=%0b ready=%0b d=%0d, expected 1 1 2", d_valid, a_ready, d);
    end
    @(negedge clk);
    a_valid = 1'b0;
    vectors++;
    if ({d_valid, d} !== {1'b1, 2'd3}) begin
      miscompares++;
      $display("FAIL bp_third: got valid=%0b d=%0d, expected 1 3", d_valid, d);
    end
    @(negedge clk);
    vectors++;
    if (d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain: got valid=%0b, expected 0", d_valid);
    end
  endtask

  task automatic test_random();
    int exp_q[$];
    int sent, rcvd, cycles;
    bit acc, drn;
    sent = 0; rcvd = 0; cycles = 0;
    while (rcvd < 1000 && cycles < 20000) begin
      vectors++;
      if (d_valid !== (exp_q.size() > 0) || a_ready !== (exp_q.size() < 2)) begin
        miscompares++;
        $display("FAIL rand_flags: got valid=%0b ready=%0b, expected occupancy %0d", d_valid, a_ready, exp_q.size());
      end
      if (d_valid === 1'b1 && exp_q.size() > 0) begin
        vectors++;
        if ({int'(d), int'(ovf)} !== {exp_q[0] % 4, exp_q[0] / 4}) begin
          miscompares++;
          $display("FAIL rand_data[%0d]: got d=%0d ovf=%0b, expected %0d %0d", rcvd, d, ovf, exp_q[0] % 4, exp_q[0] / 4);
        end
      end
      a_valid = (sent < 1000) && ($urandom_range(0, 1) == 1);
      a       = 2'($urandom_range(0, 3));
      d_ready = ($urandom_range(0, 1) == 1);
      acc = a_valid && a_ready;
      drn = d_valid && d_ready;
      if (drn && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        rcvd++;
      end
      if (acc) begin
        exp_q.push_back(ref_d(int'(a), 2) + 4 * ref_ovf(int'(a), 2));
        sent++;
      end
      @(negedge clk);
      cycles++;
    end
    a_valid = 1'b0;
    vectors++;
    if (rcvd != 1000) begin
      miscompares++;
      $display("FAIL rand_count: got %0d results, expected 1000", rcvd);
    end
  endtask

  task automatic test_reset_full();
    d_ready = 1'b0; a_valid = 1'b1; a = 2'd1;
    @(negedge clk);
    a = 2'd2;
    @(negedge clk);
    vectors++;
    if ({d_valid, a_ready} !== {1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL rf_full: got valid=%0b ready=%0b, expected 1 0", d_valid, a_ready);
    end
    rst = 1'b1; d_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; a_valid = 1'b0;
    vectors++;
    if ({d_valid, a_ready, d, ovf} !== {1'b0, 1'b1, 2'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL rf_reset: got valid=%0b ready=%0b d=%0d ovf=%0b, expected 0 1 0 0", d_valid, a_ready, d, ovf);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (d_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL rf_stale[%0d]: got valid=%0b, expected 0", i, d_valid);
      end
    end
  endtask

  task automatic test_width8();
    int ops[2];
    ops[0] = 255; ops[1] = 127;
    d8_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a8 = 8'(ops[i]); a8_valid = 1'b1;
      @(negedge clk);
      vectors++;
      if ({d8_valid, int'(d8), int'(ovf8)} !== {1'b1, ref_d(ops[i], 8), ref_ovf(ops[i], 8)}) begin
        miscompares++;
        $display("FAIL w8[%0h]: got valid=%0b d=%0h ovf=%0b, expected 1 %0h %0d",
                 ops[i], d8_valid, d8, ovf8, ref_d(ops[i], 8), ref_ovf(ops[i], 8));
      end
    end
    a8_valid = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1; a_valid = 1'b0; a = 2'd0; d_ready = 1'b0;
    a8_valid = 1'b0; a8 = 8'd0; d8_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_full();
    test_width8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
